// File: rtl/fetch_decode_queue.sv
// RV32I fetch front end: sequential fetch into a small queue,
// head entry fully decoded and handed to execute via valid/ready.
module fetch_decode_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      func3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic [AW:0]     occupancy;
  logic            push;
  logic            pop;
  logic [31:0]     head;
  logic [31:0]     imm32;
  logic            unused_ok;

  assign unused_ok = &{1'b0, redirect_pc[1:0]};

  // In-flight fetch reserves a slot so its response always fits.
  assign occupancy = count + {{AW{1'b0}}, inflight};
  assign imem_req  = !reset && !redirect && (occupancy < FULL);
  assign imem_addr = fetch_pc;
  assign id_valid  = !reset && !redirect && (count != '0);
  assign push      = inflight && !redirect;
  assign pop       = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_q[wptr]    <= inflight_pc;
      instr_q[wptr] <= imem_rdata;
    end
  end

  assign head = instr_q[rptr];

  always_comb begin
    id_pc    = '0;
    id_instr = '0;
    opcode   = '0;
    rd       = '0;
    func3    = '0;
    rs1      = '0;
    rs2      = '0;
    func7    = '0;
    imm32    = '0;
    illegal  = 1'b0;
    if (id_valid) begin
      id_pc    = pc_q[rptr];
      id_instr = head;
      opcode   = head[6:0];
      rd       = head[11:7];
      func3    = head[14:12];
      rs1      = head[19:15];
      rs2      = head[24:20];
      func7    = head[31:25];
      unique case (head[6:0])
        7'h03, 7'h13, 7'h67, 7'h73:
          imm32 = {{20{head[31]}}, head[31:20]};
        7'h23:
          imm32 = {{20{head[31]}}, head[31:25], head[11:7]};
        7'h63:
          imm32 = {{19{head[31]}}, head[31], head[7],
                   head[30:25], head[11:8], 1'b0};
        7'h37, 7'h17:
          imm32 = {head[31:12], 12'b0};
        7'h6f:
          imm32 = {{11{head[31]}}, head[31], head[19:12],
                   head[20], head[30:21], 1'b0};
        7'h33, 7'h0f:
          imm32 = '0;
        default:
          illegal = 1'b1;
      endcase
    end
  end

  assign imm = XLEN'($signed(imm32));

endmodule
